// File: rtl/store_drain_ctrl_pkg.sv
// Shared sizing and FSM encodings for the store drain controller.
// Mirrors the legacy constants header values.
package store_drain_ctrl_pkg;

  localparam int SQ_NUM         = 16;
  localparam int SQ_SEL         = 4;
  localparam int ADDR_LEN       = 32;
  localparam int DATA_LEN       = 32;
  localparam int SQ_ACK_TIMEOUT = 255;
  localparam int CNT_W          = SQ_SEL + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_POP  = 2'd2;

endpackage

// File: rtl/store_drain_ctrl_if.sv
// Memory write port: request with stable address/data,
// completed by a single-cycle acknowledge.
interface store_drain_ctrl_if;
  import store_drain_ctrl_pkg::*;

  logic                mem_wreq;
  logic [ADDR_LEN-1:0] mem_waddr;
  logic [DATA_LEN-1:0] mem_wdata;
  logic                mem_wack;

  modport master (
    output mem_wreq,
    output mem_waddr,
    output mem_wdata,
    input  mem_wack
  );

  modport slave (
    input  mem_wreq,
    input  mem_waddr,
    input  mem_wdata,
    output mem_wack
  );

endinterface

// File: rtl/store_drain_ctrl_pending_counter.sv
// Committed-but-undrained store count: up by 0..2, down by 0..1,
// with a stall output that blocks commits near capacity.
module pending_counter
  import store_drain_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             stall
);

  logic [CNT_W-1:0] add;

  // Stalling at SQ_NUM-1 leaves headroom for a dual commit.
  assign stall = count >= CNT_W'(SQ_NUM - 1);
  assign add   = stall ? '0 : CNT_W'(inc);

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else begin
      count <= count + add - CNT_W'(dec);
    end
  end

endmodule

// File: rtl/store_drain_ctrl.sv
// Drains committed stores from the SQ head into memory,
// one write at a time, then pulses a pop back to the SQ.
module store_drain_ctrl
  import store_drain_ctrl_pkg::*;
#(
  parameter int ACK_TIMEOUT = SQ_ACK_TIMEOUT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                commit_store_1,
  input  logic                commit_store_2,
  input  logic                sq_empty,
  input  logic                sq_head_calculated,
  input  logic [ADDR_LEN-1:0] sq_head_address,
  input  logic [DATA_LEN-1:0] sq_head_data,
  output logic                sq_pop,
  store_drain_ctrl_if.master  mem,
  output logic                commit_stall,
  output logic [CNT_W-1:0]    pending_count,
  output logic                drain_busy,
  output logic                mem_err
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  logic [1:0]    state;
  logic [1:0]    comnum;
  logic [TW-1:0] tcnt;
  logic          issue;

  assign comnum = {1'b0, commit_store_1}
                + {1'b0, commit_store_2};

  pending_counter u_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (comnum),
    .dec   (sq_pop),
    .count (pending_count),
    .stall (commit_stall)
  );

  assign issue = (pending_count != '0)
              && !sq_empty
              && sq_head_calculated;

  assign drain_busy = (state != S_IDLE)
                   || (pending_count != '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= S_IDLE;
      sq_pop        <= 1'b0;
      mem.mem_wreq  <= 1'b0;
      mem.mem_waddr <= '0;
      mem.mem_wdata <= '0;
      mem_err       <= 1'b0;
      tcnt          <= '0;
    end else begin
      sq_pop <= 1'b0;
      unique case (1'b1)
        (state == S_IDLE): begin
          if (issue) begin
            state         <= S_REQ;
            mem.mem_wreq  <= 1'b1;
            mem.mem_waddr <= sq_head_address;
            mem.mem_wdata <= sq_head_data;
            tcnt          <= '0;
          end
        end
        (state == S_REQ): begin
          if (mem.mem_wack) begin
            state        <= S_POP;
            mem.mem_wreq <= 1'b0;
            sq_pop       <= 1'b1;
          end else begin
            if (tcnt != TW'(ACK_TIMEOUT))
              tcnt <= tcnt + 1'b1;
            // Error flags on the edge the count reaches the limit.
            if (tcnt == TW'(ACK_TIMEOUT - 1))
              mem_err <= 1'b1;
          end
        end
        (state == S_POP): begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_drain_ctrl.sv
// Self-checking bench: vector table for commit/stall counting,
// scoreboarded memory writes, and hand-written corner sequences.
module tb_store_drain_ctrl;
  import store_drain_ctrl_pkg::*;

  typedef struct packed {
    logic [ADDR_LEN-1:0] a;
    logic [DATA_LEN-1:0] d;
  } wr_t;

  typedef struct {
    bit c1;
    bit c2;
    int pend;
    bit stall;
  } vec_t;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                commit_store_1 = 1'b0;
  logic                commit_store_2 = 1'b0;
  logic                sq_empty = 1'b1;
  logic                sq_head_calculated = 1'b0;
  logic [ADDR_LEN-1:0] sq_head_address = '0;
  logic [DATA_LEN-1:0] sq_head_data = '0;
  logic                sq_pop;
  logic                commit_stall;
  logic [CNT_W-1:0]    pending_count;
  logic                drain_busy;
  logic                mem_err;

  store_drain_ctrl_if mem_if ();

  store_drain_ctrl dut (
    .clk                (clk),
    .reset              (reset),
    .commit_store_1     (commit_store_1),
    .commit_store_2     (commit_store_2),
    .sq_empty           (sq_empty),
    .sq_head_calculated (sq_head_calculated),
    .sq_head_address    (sq_head_address),
    .sq_head_data       (sq_head_data),
    .sq_pop             (sq_pop),
    .mem                (mem_if.master),
    .commit_stall       (commit_stall),
    .pending_count      (pending_count),
    .drain_busy         (drain_busy),
    .mem_err            (mem_err)
  );

  always #5 clk = ~clk;

  wr_t sq_q[$];
  wr_t exp_q[$];
  wr_t cap;
  int  total = 0;
  int  bad = 0;
  int  m_pend = 0;
  int  pops = 0;
  int  pops0 = 0;
  int  wlen = 0;
  int  ack_delay = 0;
  int  exp_len = 1;
  int  seq = 0;
  bit  ack_en = 1'b1;
  bit  force_empty = 1'b0;
  bit  calc_en = 1'b1;
  vec_t vt[12];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    total++;
    bad++;
    $display("FAIL %s", nm);
  endtask

  // Memory responder, scoreboard and SQ model, then one clock.
  task automatic tick();
    wr_t w;
    @(negedge clk);
    if (mem_if.mem_wreq) begin
      if (wlen == 0)
        cap = {mem_if.mem_waddr, mem_if.mem_wdata};
      else
        chk("wr_stable",
            {mem_if.mem_waddr, mem_if.mem_wdata}, cap);
      wlen++;
      mem_if.mem_wack = ack_en && (wlen > ack_delay);
      if (mem_if.mem_wack) begin
        if (exp_q.size() == 0) begin
          fail_now("wr_unexpected");
        end else begin
          w = exp_q.pop_front();
          chk("wr_addr", mem_if.mem_waddr, w.a);
          chk("wr_data", mem_if.mem_wdata, w.d);
          if (exp_len > 0)
            chk("wr_len", wlen, exp_len);
        end
      end
    end else begin
      wlen = 0;
      mem_if.mem_wack = 1'b0;
    end
    if (sq_pop) begin
      pops++;
      m_pend--;
      if (sq_q.size() > 0)
        sq_q.delete(0);
    end
    sq_empty = force_empty || (sq_q.size() == 0);
    sq_head_calculated = calc_en && (sq_q.size() > 0);
    if (sq_q.size() > 0) begin
      sq_head_address = sq_q[0].a;
      sq_head_data    = sq_q[0].d;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic commit(input bit c1, input bit c2);
    wr_t w;
    int  n;
    n = int'(c1) + int'(c2);
    commit_store_1 = c1;
    commit_store_2 = c2;
    if (m_pend < SQ_NUM - 1) begin
      for (int i = 0; i < n; i++) begin
        w.a = 32'h100 + 32'(seq * 4);
        w.d = 32'hDEAD + 32'(seq * 17);
        seq++;
        sq_q.push_back(w);
        exp_q.push_back(w);
      end
      m_pend += n;
    end
    tick();
    commit_store_1 = 1'b0;
    commit_store_2 = 1'b0;
  endtask

  task automatic wait_wreq(input int budget);
    int n = 0;
    while (!mem_if.mem_wreq && n < budget) begin
      tick();
      n++;
    end
    if (!mem_if.mem_wreq)
      fail_now("wreq_wait_timeout");
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (m_pend != 0 && n < budget) begin
      tick();
      n++;
    end
    if (m_pend != 0)
      fail_now("drain_timeout");
    chk("drain_pending", pending_count, 0);
    chk("drain_busy", drain_busy, 0);
  endtask

  initial begin
    vt[0]  = '{1, 0, 1, 0};
    vt[1]  = '{1, 1, 3, 0};
    vt[2]  = '{0, 0, 3, 0};
    vt[3]  = '{0, 1, 4, 0};
    vt[4]  = '{1, 1, 6, 0};
    vt[5]  = '{1, 1, 8, 0};
    vt[6]  = '{1, 1, 10, 0};
    vt[7]  = '{1, 1, 12, 0};
    vt[8]  = '{1, 1, 14, 0};
    vt[9]  = '{1, 0, 15, 1};
    vt[10] = '{1, 1, 15, 1};
    vt[11] = '{0, 1, 15, 1};

    mem_if.mem_wack = 1'b0;
    reset = 1'b0;
    tick();
    tick();
    chk("rst_wreq", mem_if.mem_wreq, 0);
    chk("rst_waddr", mem_if.mem_waddr, 0);
    chk("rst_wdata", mem_if.mem_wdata, 0);
    chk("rst_pop", sq_pop, 0);
    chk("rst_pending", pending_count, 0);
    chk("rst_err", mem_err, 0);
    chk("rst_busy", drain_busy, 0);
    chk("rst_stall", commit_stall, 0);
    reset = 1'b1;
    tick();

    // Single store, same-cycle ack.
    commit(1'b1, 1'b0);
    chk("s1_pend", pending_count, 1);
    chk("s1_wreq0", mem_if.mem_wreq, 0);
    tick();
    chk("s1_wreq", mem_if.mem_wreq, 1);
    chk("s1_addr", mem_if.mem_waddr, 32'h100);
    chk("s1_data", mem_if.mem_wdata, 32'hDEAD);
    tick();
    chk("s1_wreq_off", mem_if.mem_wreq, 0);
    chk("s1_pop", sq_pop, 1);
    chk("s1_pend_pop", pending_count, 1);
    tick();
    chk("s1_pop_off", sq_pop, 0);
    chk("s1_pend_end", pending_count, 0);

    // Dual commit, ack three cycles after request.
    ack_delay = 3;
    exp_len = 4;
    pops0 = pops;
    commit(1'b1, 1'b1);
    chk("dual_pend", pending_count, 2);
    wait_drain(100);
    chk("dual_pops", pops - pops0, 2);

    // Counting and stall boundary with the SQ held empty.
    force_empty = 1'b1;
    ack_delay = 0;
    exp_len = 1;
    tick();
    for (int i = 0; i < 12; i++) begin
      commit(vt[i].c1, vt[i].c2);
      chk($sformatf("vec%0d_pend", i),
          pending_count, vt[i].pend);
      chk($sformatf("vec%0d_stall", i),
          commit_stall, vt[i].stall);
      chk($sformatf("vec%0d_busy", i),
          drain_busy, vt[i].pend != 0);
      chk($sformatf("vec%0d_wreq", i),
          mem_if.mem_wreq, 0);
    end
    force_empty = 1'b0;
    pops0 = pops;
    wait_drain(300);
    chk("stall_pops", pops - pops0, 15);
    chk("stall_q", exp_q.size(), 0);

    // Head not yet calculated holds the FSM idle.
    calc_en = 1'b0;
    commit(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("uncalc_wreq%0d", i),
          mem_if.mem_wreq, 0);
      chk($sformatf("uncalc_pend%0d", i),
          pending_count, 1);
    end
    calc_en = 1'b1;
    wait_wreq(10);
    chk("uncalc_go", mem_if.mem_wreq, 1);
    wait_drain(20);

    // Ack timeout sets a sticky error, write still completes.
    ack_en = 1'b0;
    exp_len = 0;
    commit(1'b1, 1'b0);
    wait_wreq(10);
    chk("to_err0", mem_err, 0);
    repeat (254) tick();
    chk("to_err254", mem_err, 0);
    chk("to_wreq254", mem_if.mem_wreq, 1);
    tick();
    chk("to_err255", mem_err, 1);
    chk("to_wreq255", mem_if.mem_wreq, 1);
    tick();
    chk("to_wreq256", mem_if.mem_wreq, 1);
    ack_en = 1'b1;
    pops0 = pops;
    wait_drain(20);
    chk("to_pops", pops - pops0, 1);
    chk("to_err_sticky", mem_err, 1);
    exp_len = 1;

    // Reset while a request is outstanding.
    ack_en = 1'b0;
    commit(1'b1, 1'b0);
    wait_wreq(10);
    tick();
    reset = 1'b0;
    pops0 = pops;
    tick();
    chk("mid_wreq", mem_if.mem_wreq, 0);
    chk("mid_pend", pending_count, 0);
    chk("mid_pop", sq_pop, 0);
    chk("mid_err", mem_err, 0);
    reset = 1'b1;
    sq_q.delete();
    exp_q.delete();
    m_pend = 0;
    ack_en = 1'b1;
    repeat (4) tick();
    chk("mid_no_pop", pops - pops0, 0);
    chk("mid_idle", drain_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/store_drain_ctrl.md
Name: store_drain_ctrl

Overview:
Sequences retirement of committed stores out of the store queue into data memory. Tracks how many SQ entries the ROB has committed but not yet written. Issues one memory write at a time from the SQ head over a req/ack handshake, then pulses a pop back to the SQ. Sits between the ROB commit ports, the store queue head, and the D-cache/memory write port.

Parameters:
SQ_NUM, 16 (from constants.vh `SQ_NUM), store queue depth; pending counter saturation bound.
ADDR_LEN, 32 (from `ADDR_LEN), address width.
DATA_LEN, 32 (from `DATA_LEN), data width.
ACK_TIMEOUT, 255, cycles in REQ without mem_wack before mem_err sets.

Ports:
clk  in  1  single clock; all state updates on posedge.
reset  in  1  synchronous, active-low reset (asserted when 0, sampled on posedge clk).
commit_store_1  in  1  ROB way-1 retires a store this cycle.
commit_store_2  in  1  ROB way-2 retires a store this cycle.
sq_empty  in  1  SQ holds no entries.
sq_head_calculated  in  1  SQ head entry has its address computed.
sq_head_address  in  ADDR_LEN  address of SQ head entry.
sq_head_data  in  DATA_LEN  data of SQ head entry.
sq_pop  out  1  one-cycle pulse; SQ retires its head entry.
mem_wreq  out  1  write request to memory.
mem_waddr  out  ADDR_LEN  write address, stable while mem_wreq=1.
mem_wdata  out  DATA_LEN  write data, stable while mem_wreq=1.
mem_wack  in  1  memory accepted the write (valid only while mem_wreq=1).
commit_stall  out  1  ROB must not retire stores this cycle.
pending_count  out  SQ_SEL+1  committed, not-yet-drained stores.
drain_busy  out  1  FSM not in IDLE or pending_count != 0.
mem_err  out  1  sticky; ack timeout occurred.

Behaviour:
- Reset (reset==0 at posedge): state=IDLE, pending_count=0, sq_pop=0, mem_wreq=0, mem_waddr=0, mem_wdata=0, mem_err=0, timeout counter=0. Reset mid-REQ drops mem_wreq at that edge; an in-flight write is abandoned, no pop issued.
- comnum = commit_store_1 + commit_store_2 (0..2). Commits are counted only when commit_stall==0; while stalled they are ignored.
- commit_stall = (pending_count >= SQ_NUM-1), combinational from the register.
- pending_count next = pending_count + comnum - (sq_pop ? 1 : 0). Simultaneous commit and pop in the same cycle are both applied. Width SQ_SEL+1; the value never exceeds SQ_NUM.
- FSM states: IDLE, REQ, POP.
  - IDLE -> REQ when pending_count>0 && !sq_empty && sq_head_calculated. On that edge, latch mem_waddr/mem_wdata from sq_head_*, set mem_wreq=1, clear the timeout counter.
  - IDLE stays in IDLE if pending_count>0 but the head is not calculated. The head is never skipped; ordering is strictly in order.
  - REQ: hold mem_wreq=1 and keep addr/data unchanged. On mem_wack: go to POP, mem_wreq=0 at that edge. Without ack: the timeout counter increments (saturating). When it reaches ACK_TIMEOUT, set mem_err=1 and remain in REQ.
  - POP: sq_pop=1 for exactly this cycle and pending decrements. Always return to IDLE.
- Latency: minimum 3 cycles per store (IDLE->REQ->POP->IDLE) with same-cycle ack. Back-to-back stores are separated by one IDLE cycle.
- sq_pop is a registered output, high only in POP.
- sq_empty with pending_count>0: the controller stays in IDLE and does not flag an error.
- mem_err clears only on reset.

Decomposition:
- DATA_LEN, ADDR_LEN, SQ_NUM and SQ_SEL come from constants.vh. Add the FSM state encodings (IDLE=2'd0, REQ=2'd1, POP=2'd2) and `SQ_ACK_TIMEOUT there.
- One natural sub-module: pending_counter, an up-by-0..2 / down-by-0..1 counter with a saturation-stall output. Everything else stays inline.

Test Plan:
- Reset then single store: commit_store_1 pulse, head calculated with addr=0x100, data=0xDEAD, ack on the first REQ cycle. Required: mem_wreq high 1 cycle with 0x100/0xDEAD, sq_pop pulses on the next cycle, pending goes 1->0.
- Dual commit with delayed ack: both commit ports fire, ack arrives 3 cycles after wreq. Required: pending=2, then two writes in order with wreq held 4 cycles each and addr/data stable, two sq_pop pulses, pending ends at 0.
- Stall boundary (SQ_NUM=16): commit until pending=15, then try another commit. Required: commit_stall=1, pending stays 15, and it drains to 0 after 15 pops.
- Uncalculated head: pending=1, sq_head_calculated=0 for 5 cycles, then 1. Required: FSM remains in IDLE with mem_wreq=0 for 5 cycles, then the issue proceeds.
- Timeout: hold mem_wack=0 for 256 cycles. Required: mem_err=1 after 255 REQ cycles, mem_wreq still 1. A later ack completes the pop and mem_err stays 1.
- Reset mid-REQ: drive reset=0 during REQ. Required: at that edge mem_wreq=0, pending=0, no sq_pop, mem_err=0.
